minimips_ctrl_fsm: RTL and testbench

- Multi-cycle main control unit for the MiniMips datapath.
- Sequences fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select.
- Generates the 3-bit ALUop consumed by the ALU-control decoder; ALUop 111 hands ALU function selection to the instruction's Func field.
- Handles a variable-latency memory through a ready handshake, and signals halt, illegal opcode and instruction retirement.

---
 rtl/minimips_ctrl_fsm_if.sv | 38 +++
 rtl/minimips_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_minimips_ctrl_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/minimips_ctrl_fsm_if.sv
// Control bundle between the MiniMips main control FSM (master) and the datapath (slave).
// Carries the IR opcode and memory handshake in, and every enable, mux select and status flag out.
interface minimips_ctrl_fsm_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       BranchNe;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUop;
    logic [3:0] state;
    logic       halted;
    logic       illegal;
    logic       retire;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, BranchNe, PCSource, ALUSrcB, ALUop,
               state, halted, illegal, retire
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, BranchNe, PCSource, ALUSrcB, ALUop,
               state, halted, illegal, retire
    );
endinterface

// File: rtl/minimips_ctrl_fsm.sv
// MiniMips multi-cycle main control: Moore outputs from state, mem_ready-qualified in FETCH/MEM_RD/MEM_WR.
// Define MINIMIPS_BNE_EN to decode opcode 1000 as bne; otherwise it is illegal and BranchNe stays 0.
module minimips_ctrl_fsm (
    input  logic                  clk,
    input  logic                  rst,
    minimips_ctrl_fsm_if.master   bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_WB_R     = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_WB_I     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SLTI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

`ifdef MINIMIPS_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= bus.opcode;
        end
    end

    assign bus.state = state_q;

    // Encodings 13-15 fall through to the all-zero defaults and return to FETCH.
    always_comb begin
        state_d         = S_FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUop       = 3'b000;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;
        bus.retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_R:                             state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_HALT:                          state_d = S_HALT;
                    OP_BNE: begin
                        if (BNE_EN) begin
                            state_d = S_BRANCH;
                        end else begin
                            bus.illegal = 1'b1;
                            bus.retire  = 1'b1;
                        end
                    end
                    default: begin
                        bus.illegal = 1'b1;
                        bus.retire  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                state_d     = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            S_MEM_WR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                bus.retire   = bus.mem_ready;
                state_d      = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = 3'b111;
                state_d     = S_WB_R;
            end
            S_WB_R: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (op_q)
                    OP_ANDI: bus.ALUop = 3'b010;
                    OP_ORI:  bus.ALUop = 3'b011;
                    OP_SLTI: bus.ALUop = 3'b100;
                    default: bus.ALUop = 3'b000;
                endcase
                state_d = S_WB_I;
            end
            S_WB_I: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUop       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNe    = BNE_EN && (op_q == OP_BNE);
                bus.retire      = 1'b1;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                bus.retire   = 1'b1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                state_d    = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_minimips_ctrl_fsm.sv
// Directed bench for minimips_ctrl_fsm: stimulus queues per-cycle expected outputs, a negedge monitor compares.
// Honors MINIMIPS_BNE_EN for the expected bne behaviour.
module tb_minimips_ctrl_fsm;
    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic       branchne;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       halted;
        logic       illegal;
        logic       retire;
    } exp_t;

    typedef struct {
        string name;
        exp_t  v;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    item_t sb[$];

    minimips_ctrl_fsm_if bus ();

    minimips_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = '0;
        e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy;
        return e;
    endfunction
    function automatic exp_t e_decode(input logic ill);
        exp_t e = '0;
        e.state = 4'd1; e.alusrcb = 2'b11; e.illegal = ill; e.retire = ill;
        return e;
    endfunction
    function automatic exp_t e_memaddr();
        exp_t e = '0;
        e.state = 4'd2; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        return e;
    endfunction
    function automatic exp_t e_memrd();
        exp_t e = '0;
        e.state = 4'd3; e.iord = 1'b1; e.memread = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwb();
        exp_t e = '0;
        e.state = 4'd4; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_memwr(input logic rdy);
        exp_t e = '0;
        e.state = 4'd5; e.iord = 1'b1; e.memwrite = 1'b1; e.retire = rdy;
        return e;
    endfunction
    function automatic exp_t e_execr();
        exp_t e = '0;
        e.state = 4'd6; e.alusrca = 1'b1; e.aluop = 3'b111;
        return e;
    endfunction
    function automatic exp_t e_wbr();
        exp_t e = '0;
        e.state = 4'd7; e.regdst = 1'b1; e.regwrite = 1'b1; e.retire = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_execi(input logic [2:0] aop);
        exp_t e = '0;
        e.state = 4'd8; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = aop;
        return e;
    endfunction
    function automatic exp_t e_wbi();
        exp_t e = '0;
        e.state = 4'd9; e.regwrite = 1'b1; e.retire = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_branch(input logic ne);
        exp_t e = '0;
        e.state = 4'd10; e.alusrca = 1'b1; e.aluop = 3'b001; e.pcwritecond = 1'b1;
        e.pcsource = 2'b01; e.branchne = ne; e.retire = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_jump();
        exp_t e = '0;
        e.state = 4'd11; e.pcwrite = 1'b1; e.pcsource = 2'b10; e.retire = 1'b1;
        return e;
    endfunction
    function automatic exp_t e_halt();
        exp_t e = '0;
        e.state = 4'd12; e.halted = 1'b1;
        return e;
    endfunction

    // Queue the outputs expected during the current cycle, then advance one clock.
    task automatic step(input string n, input exp_t e);
        item_t it;
        it.name = n;
        it.v    = e;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [3:0] op);
        bus.opcode    = op;
        bus.mem_ready = 1'b1;
        step("fetch", e_fetch(1'b1));
        step("decode", e_decode(1'b0));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            exp_t  act;
            it  = sb.pop_front();
            act = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                   bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                   bus.ALUSrcA, bus.BranchNe, bus.PCSource, bus.ALUSrcB, bus.ALUop,
                   bus.halted, bus.illegal, bus.retire};
            n_cmp++;
            if (act !== it.v) begin
                n_bad++;
                $display("FAIL %s: got 0x%07h (state %0d) expected 0x%07h (state %0d)",
                         it.name, act, act.state, it.v, it.v.state);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] iop [3];
        logic [2:0] ialu [3];
        iop[0] = 4'b0001; ialu[0] = 3'b000;
        iop[1] = 4'b0010; ialu[1] = 3'b010;
        iop[2] = 4'b0100; ialu[2] = 3'b100;

        rst = 1'b1; bus.opcode = 4'b0000; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        step("reset_0", e_fetch(1'b0));
        step("reset_1", e_fetch(1'b0));
        rst = 1'b0;

        // R-type
        fetch_decode(4'b0000);
        step("exec_r", e_execr());
        step("wb_r", e_wbr());

        // lw with 3 wait cycles; opcode scrambled after DECODE to exercise the latched copy
        fetch_decode(4'b0101);
        bus.opcode = 4'b0110;
        step("lw_memaddr", e_memaddr());
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_memrd_wait", e_memrd());
        bus.mem_ready = 1'b1;
        step("lw_memrd_rdy", e_memrd());
        step("lw_memwb", e_memwb());

        // ori, with opcode changed during EXEC_I
        fetch_decode(4'b0011);
        bus.opcode = 4'b0001;
        step("ori_exec", e_execi(3'b011));
        step("ori_wb", e_wbi());

        for (int k = 0; k < 3; k++) begin
            fetch_decode(iop[k]);
            step("imm_exec", e_execi(ialu[k]));
            step("imm_wb", e_wbi());
        end

        // sw with one wait
        fetch_decode(4'b0110);
        step("sw_memaddr", e_memaddr());
        bus.mem_ready = 1'b0;
        step("sw_memwr_wait", e_memwr(1'b0));
        bus.mem_ready = 1'b1;
        step("sw_memwr_rdy", e_memwr(1'b1));

        fetch_decode(4'b0111);
        step("beq_branch", e_branch(1'b0));

        bus.opcode = 4'b1000; bus.mem_ready = 1'b1;
        step("fetch", e_fetch(1'b1));
`ifdef MINIMIPS_BNE_EN
        step("decode", e_decode(1'b0));
        step("bne_branch", e_branch(1'b1));
`else
        step("bne_illegal", e_decode(1'b1));
`endif

        fetch_decode(4'b1001);
        step("jump", e_jump());

        bus.opcode = 4'b1010;
        step("fetch", e_fetch(1'b1));
        step("illegal_1010", e_decode(1'b1));

        // FETCH wait then R-type continues
        bus.opcode = 4'b0000; bus.mem_ready = 1'b0;
        step("fetch_wait", e_fetch(1'b0));
        bus.mem_ready = 1'b1;
        step("fetch_rdy", e_fetch(1'b1));
        step("decode", e_decode(1'b0));
        step("exec_r2", e_execr());
        step("wb_r2", e_wbr());

        // reset during MEM_WR wait aborts the store without a retire
        fetch_decode(4'b0110);
        step("sw2_memaddr", e_memaddr());
        bus.mem_ready = 1'b0;
        step("sw2_memwr_wait", e_memwr(1'b0));
        rst = 1'b1;
        step("sw2_memwr_rst", e_memwr(1'b0));
        rst = 1'b0;
        step("sw2_after_rst", e_fetch(1'b0));

        // halt is sticky regardless of opcode and mem_ready
        fetch_decode(4'b1111);
        bus.opcode = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            step("halt_hold", e_halt());
        end
        rst = 1'b1; bus.mem_ready = 1'b0;
        step("halt_rst_cycle", e_halt());
        rst = 1'b0;
        step("halt_after_rst", e_fetch(1'b0));
        bus.mem_ready = 1'b1;
        step("post_halt_fetch", e_fetch(1'b1));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
